// File: rtl/acc_pkg.sv
// -----------------------------------------------------------------------------
// acc_pkg
// Shared definitions for the parameterised block accumulator:
//   - acc_state_t   : accumulator FSM states (ACCUM collects samples,
//                     DONE presents the block result)
//   - DEF_IN_W      : default unsigned sample width
//   - DEF_ACC_W     : default accumulator width (must be >= IN_W + 1)
//   - DEF_N_SAMPLES : default number of samples per block (must be >= 1)
// -----------------------------------------------------------------------------
package acc_pkg;

  localparam int DEF_IN_W      = 4;
  localparam int DEF_ACC_W     = 8;
  localparam int DEF_N_SAMPLES = 4;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } acc_state_t;

endpackage

// File: rtl/acc_addsub.sv
// -----------------------------------------------------------------------------
// acc_addsub
// Width-parametric unsigned adder/subtractor used by the accumulator datapath.
// Ports:
//   a     [W-1:0] in  : left operand (current accumulator value)
//   b     [W-1:0] in  : right operand (zero-extended sample)
//   sub           in  : 1 computes a - b, 0 computes a + b
//   sum   [W-1:0] out : result modulo 2^W
//   carry         out : carry-out on add, borrow on subtract
// -----------------------------------------------------------------------------
module acc_addsub #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         carry
);

  // One extra bit on the operands: its value after the operation is the
  // carry on an add and the borrow (a < b) on a subtract.
  logic [W:0] wide;

  always_comb begin
    if (sub) begin
      wide = {1'b0, a} - {1'b0, b};
    end else begin
      wide = {1'b0, a} + {1'b0, b};
    end
  end

  assign sum   = wide[W-1:0];
  assign carry = wide[W];

endmodule

// File: rtl/param_accumulator.sv
// -----------------------------------------------------------------------------
// param_accumulator
// Accumulates N_SAMPLES unsigned samples (each added or subtracted) into a
// block result, handed out through a valid/ready handshake.
//
// Optional feature macro: ACC_SAT_EN
//   undefined : arithmetic wraps modulo 2^ACC_W
//   defined   : arithmetic saturates (add clamps to all ones, subtract to 0)
//   In both cases ovf is a sticky per-block flag set on carry/borrow.
//
// Ports:
//   clk                 in  : clock, all state changes on rising edge
//   rst                 in  : asynchronous active-low reset
//   clr                 in  : synchronous block restart, beats everything else
//   in_valid / in_ready     : sample handshake (ready only while accumulating)
//   in_data  [IN_W-1:0] in  : unsigned sample
//   in_sub              in  : 1 subtracts the sample, 0 adds it
//   acc      [ACC_W-1:0] out: running accumulator value
//   out_valid / out_ready   : block result handshake
//   out_data [ACC_W-1:0] out: registered block result, stable while out_valid
//   ovf                 out : sticky overflow/underflow for the current block
//   cnt                 out : samples accepted in the current block
// -----------------------------------------------------------------------------
module param_accumulator
  import acc_pkg::*;
#(
  parameter int IN_W      = DEF_IN_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int N_SAMPLES = DEF_N_SAMPLES
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [IN_W-1:0]                in_data,
  input  logic                           in_sub,
  output logic [ACC_W-1:0]               acc,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ACC_W-1:0]               out_data,
  output logic                           ovf,
  output logic [$clog2(N_SAMPLES+1)-1:0] cnt
);

  localparam int CNT_W = $clog2(N_SAMPLES + 1);

  acc_state_t       state;
  logic             accept;
  logic             last_sample;
  logic [ACC_W-1:0] sample_ext;
  logic [ACC_W-1:0] raw_sum;
  logic [ACC_W-1:0] next_acc;
  logic             carry;

  // Handshake outputs are pure decodes of the state, so an asynchronous reset
  // drops out_valid and raises in_ready without waiting for a clock.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);

  // A restart in the same cycle wins, so the sample offered with it is lost.
  assign accept      = in_valid && in_ready && !clr;
  assign last_sample = (cnt == CNT_W'(N_SAMPLES - 1));
  assign sample_ext  = {{(ACC_W - IN_W){1'b0}}, in_data};

  acc_addsub #(
    .W (ACC_W)
  ) u_addsub (
    .a     (acc),
    .b     (sample_ext),
    .sub   (in_sub),
    .sum   (raw_sum),
    .carry (carry)
  );

  // Saturation sits here rather than in the adder: on a carry the clamp
  // direction depends only on whether this was a subtract (floor) or an
  // add (ceiling). Without the macro the wrapped sum is kept as-is.
  always_comb begin
    next_acc = raw_sum;
`ifdef ACC_SAT_EN
    if (carry) begin
      next_acc = in_sub ? '0 : '1;
    end
`endif
  end

  // Block FSM and datapath registers. The final sample's post-update sum is
  // captured into out_data at the same edge the FSM enters DONE, so the
  // result stays frozen for the whole handshake. Accepting the result clears
  // the block state; the DONE cycle itself is the bubble before the next
  // sample can be taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ACCUM;
      acc      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      out_data <= '0;
    end else if (clr) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc <= next_acc;
            cnt <= cnt + CNT_W'(1);
            ovf <= ovf | carry;
            if (last_sample) begin
              state    <= DONE;
              out_data <= next_acc;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
          end
        end
        default: begin
          state <= ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_accumulator.sv
// -----------------------------------------------------------------------------
// tb_param_accumulator
// Self-checking bench for param_accumulator (IN_W=4, ACC_W=5, N_SAMPLES=4).
// Directed scenarios followed by a randomized run, all compared every cycle
// against an integer-arithmetic reference model. Honours ACC_SAT_EN.
// -----------------------------------------------------------------------------
module tb_param_accumulator;

  localparam int IN_W    = 4;
  localparam int ACC_W   = 5;
  localparam int N       = 4;
  localparam int CNT_W   = $clog2(N + 1);
  localparam int ACC_MAX = (1 << ACC_W) - 1;

  logic             clk;
  logic             rst;
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             in_sub;
  logic [ACC_W-1:0] acc;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             ovf;
  logic [CNT_W-1:0] cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_acc;
  int m_cnt;
  int m_out;
  bit m_ovf;
  bit m_done;

  param_accumulator #(
    .IN_W      (IN_W),
    .ACC_W     (ACC_W),
    .N_SAMPLES (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sub    (in_sub),
    .acc       (acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ovf       (ovf),
    .cnt       (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports a failing one.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc  = 0;
    m_cnt  = 0;
    m_out  = 0;
    m_ovf  = 1'b0;
    m_done = 1'b0;
  endtask

  // Behavioural rules: restart beats everything; a pending result waits for
  // out_ready; otherwise a valid sample is applied with plain integer math.
  task automatic model_step(input bit v, input int d, input bit s, input bit c, input bit ordy);
    int r;
    if (c) begin
      m_acc = 0; m_cnt = 0; m_ovf = 1'b0; m_done = 1'b0;
    end else if (m_done) begin
      if (ordy) begin
        m_acc = 0; m_cnt = 0; m_ovf = 1'b0; m_done = 1'b0;
      end
    end else if (v) begin
      r = s ? (m_acc - d) : (m_acc + d);
      if (r > ACC_MAX || r < 0) begin
        m_ovf = 1'b1;
`ifdef ACC_SAT_EN
        r = (r < 0) ? 0 : ACC_MAX;
`else
        r = r & ACC_MAX;
`endif
      end
      m_acc = r;
      m_cnt = m_cnt + 1;
      if (m_cnt == N) begin
        m_done = 1'b1;
        m_out  = m_acc;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    check_eq({tag, ".acc"},       32'(acc),       32'(m_acc));
    check_eq({tag, ".cnt"},       32'(cnt),       32'(m_cnt));
    check_eq({tag, ".ovf"},       32'(ovf),       32'(m_ovf));
    check_eq({tag, ".out_valid"}, 32'(out_valid), 32'(m_done));
    check_eq({tag, ".in_ready"},  32'(in_ready),  32'(!m_done));
    check_eq({tag, ".out_data"},  32'(out_data),  32'(m_out));
  endtask

  // Drive one cycle of inputs, clock it, then compare just after the edge.
  task automatic applyStimulus(input string tag, input bit v, input int d, input bit s,
                               input bit c, input bit ordy);
    in_valid  = v;
    in_data   = IN_W'(d);
    in_sub    = s;
    clr       = c;
    out_ready = ordy;
    model_step(v, d, s, c, ordy);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  // Asynchronous reset asserted between edges and checked before any clock.
  task automatic do_reset(input string tag);
    in_valid  = 1'b0;
    in_data   = '0;
    in_sub    = 1'b0;
    clr       = 1'b0;
    out_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    checkOutput({tag, ".async"});
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput({tag, ".release"});
  endtask

  initial begin
    int d034[4];
    rst       = 1'b1;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sub    = 1'b0;
    out_ready = 1'b0;
    model_reset();
    do_reset("reset");

    // Plain block of adds with the result held while out_ready stays low;
    // samples offered during DONE must be ignored.
    d034 = '{3, 5, 7, 9};
    for (int i = 0; i < 4; i++) applyStimulus("add_block", 1'b1, d034[i], 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("hold", 1'b1, 12, 1'b0, 1'b0, 1'b0);
    check_eq("sum24.out_data", 32'(out_data), 32'd24);
    check_eq("sum24.in_ready", 32'(in_ready), 32'd0);
    applyStimulus("result_accept", 1'b0, 0, 1'b0, 1'b0, 1'b1);
    applyStimulus("after_bubble", 1'b1, 1, 1'b0, 1'b0, 1'b0);
    applyStimulus("clr_after_bubble", 1'b0, 0, 1'b0, 1'b1, 1'b0);

    // Overflow on add: 4 x 15 = 60 does not fit in 5 bits.
    for (int i = 0; i < 4; i++) applyStimulus("add_ovf", 1'b1, 15, 1'b0, 1'b0, 1'b0);
`ifdef ACC_SAT_EN
    check_eq("ovf_block.out_data", 32'(out_data), 32'd31);
`else
    check_eq("ovf_block.out_data", 32'(out_data), 32'd28);
`endif
    check_eq("ovf_block.ovf", 32'(ovf), 32'd1);
    applyStimulus("ovf_accept", 1'b0, 0, 1'b0, 1'b0, 1'b1);

    // Underflow: subtract 1 from zero, then sticky ovf survives an idle
    // cycle and is cleared by clr.
    applyStimulus("sub_underflow", 1'b1, 1, 1'b1, 1'b0, 1'b0);
`ifdef ACC_SAT_EN
    check_eq("underflow.acc", 32'(acc), 32'd0);
`else
    check_eq("underflow.acc", 32'(acc), 32'd31);
`endif
    check_eq("underflow.ovf", 32'(ovf), 32'd1);
    applyStimulus("ovf_sticky", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus("clr_ovf", 1'b0, 0, 1'b0, 1'b1, 1'b0);

    // clr alongside a valid sample drops the sample.
    applyStimulus("pre_clr", 1'b1, 4, 1'b0, 1'b0, 1'b0);
    applyStimulus("pre_clr", 1'b1, 4, 1'b0, 1'b0, 1'b0);
    applyStimulus("clr_with_sample", 1'b1, 6, 1'b0, 1'b1, 1'b0);
    check_eq("clr_drop.acc", 32'(acc), 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus("post_clr", 1'b1, 1, 1'b0, 1'b0, 1'b0);
    check_eq("post_clr.out_data", 32'(out_data), 32'd4);
    applyStimulus("clr_in_done", 1'b0, 0, 1'b0, 1'b1, 1'b1);

    // Gapped in_valid: acc moves only on accepted samples.
    for (int i = 0; i < 8; i++) applyStimulus("gapped", (i % 2) == 1, 2, 1'b0, 1'b0, 1'b0);
    check_eq("gapped.out_data", 32'(out_data), 32'd8);
    applyStimulus("gapped_accept", 1'b0, 0, 1'b0, 1'b0, 1'b1);

    // Reset mid-block (cnt=2) and while holding a result in DONE.
    applyStimulus("mid_block", 1'b1, 1, 1'b0, 1'b0, 1'b0);
    applyStimulus("mid_block", 1'b1, 1, 1'b0, 1'b0, 1'b0);
    check_eq("mid_block.cnt", 32'(cnt), 32'd2);
    do_reset("rst_mid_block");
    for (int i = 0; i < 4; i++) applyStimulus("to_done", 1'b1, 2 + i, 1'b0, 1'b0, 1'b0);
    do_reset("rst_in_done");
    for (int i = 0; i < 4; i++) applyStimulus("clean_block", 1'b1, i + 1, 1'b0, 1'b0, 1'b0);
    check_eq("clean_block.out_data", 32'(out_data), 32'd10);
    applyStimulus("clean_accept", 1'b0, 0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus("random",
                    1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 15)),
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 24) == 0),
                    1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
